// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   state_t          - fetch sequencer states
//   OPC_W            - width of the opcode field at the top of an instruction
//   HALT_OP_DEFAULT  - opcode that stops fetching unless overridden
package fetch_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_ISSUE   = 3'd4,
    S_EXEC    = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  localparam int unsigned OPC_W = 3;
  localparam logic [OPC_W-1:0] HALT_OP_DEFAULT = 3'b111;

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory read port, the controller
// handshake and the status outputs of the fetch unit.
//   master - fetch unit side (drives mem_addr/mem_rd/code/start/pc/halted)
//   slave  - environment side (drives run/mem_rdata/inc_pc/branch)
interface fetch_unit_if #(
  parameter int unsigned PC_W    = 8,
  parameter int unsigned INSTR_W = 23
);
  logic               run;
  logic [PC_W-1:0]    mem_addr;
  logic               mem_rd;
  logic [INSTR_W-1:0] mem_rdata;
  logic [INSTR_W-1:0] code;
  logic               start;
  logic               inc_pc;
  logic               branch;
  logic [PC_W-1:0]    pc;
  logic               halted;

  modport master (
    input  run, mem_rdata, inc_pc, branch,
    output mem_addr, mem_rd, code, start, pc, halted
  );

  modport slave (
    output run, mem_rdata, inc_pc, branch,
    input  mem_addr, mem_rd, code, start, pc, halted
  );
endinterface

// File: rtl/fetch_unit_pc_counter.sv
// pc_counter: program counter register.
//   clk, rst - clock and synchronous active-high reset (to RESET_PC)
//   load     - load target (has priority over inc)
//   inc      - advance by one, wrapping modulo 2^PC_W
//   target   - branch target
//   pc       - current program counter
module pc_counter #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            inc,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc
);

  // PC register: load beats increment; the adder wraps naturally at PC_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= PC_W'(RESET_PC);
    end else if (load) begin
      pc <= target;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch and sequencing for the CPU controller.
//   clk, rst - clock and synchronous active-high reset
//   bus      - fetch_unit_if.master: memory read port (mem_addr, mem_rd,
//              mem_rdata), controller handshake (code, start, inc_pc,
//              branch), control/status (run, pc, halted)
// One instruction is fetched, captured, issued with a start pulse and then
// held until the controller answers with inc_pc or branch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      PC_W     = 8,
  parameter int unsigned      INSTR_W  = 23,
  parameter int unsigned      MEM_LAT  = 1,
  parameter int unsigned      RESET_PC = 0,
  parameter logic [OPC_W-1:0] HALT_OP  = HALT_OP_DEFAULT
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

  state_t             state;
  logic [CNT_W-1:0]   lat_cnt;
  logic [INSTR_W-1:0] code_reg;
  logic               mem_rd_reg;
  logic               start_reg;
  logic               halted_reg;
  logic               in_exec;
  logic               pc_load;
  logic               pc_inc;
  logic               responded;
  logic [PC_W-1:0]    pc_val;

  // Controller responses only count while an issued instruction is pending;
  // branch wins over inc_pc so the PC moves at most once.
  always_comb begin
    in_exec = 1'b0;
    if ((state == S_ISSUE) || (state == S_EXEC)) begin
      in_exec = 1'b1;
    end else begin
      in_exec = 1'b0;
    end
    pc_load   = in_exec & bus.branch;
    pc_inc    = in_exec & bus.inc_pc & ~bus.branch;
    responded = pc_load | pc_inc;
  end

  pc_counter #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .load   (pc_load),
    .inc    (pc_inc),
    .target (code_reg[PC_W-1:0]),
    .pc     (pc_val)
  );

  // Sequencer: mem_rd, start and halted are set on the transition into the
  // state that owns them, so each is high exactly while in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      code_reg   <= '0;
      mem_rd_reg <= 1'b0;
      start_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      mem_rd_reg <= 1'b0;
      start_reg  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.run) begin
            state      <= S_FETCH;
            mem_rd_reg <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_FETCH: begin
          if (MEM_LAT == 32'd1) begin
            state <= S_CAPTURE;
          end else begin
            // WAIT lasts MEM_LAT-1 cycles, counted down to 1.
            state   <= S_WAIT;
            lat_cnt <= CNT_W'(MEM_LAT - 32'd1);
          end
        end
        S_WAIT: begin
          if (lat_cnt <= CNT_W'(1)) begin
            state   <= S_CAPTURE;
            lat_cnt <= '0;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        S_CAPTURE: begin
          code_reg <= bus.mem_rdata;
          if (bus.mem_rdata[INSTR_W-1 -: OPC_W] == HALT_OP) begin
            state      <= S_HALT;
            halted_reg <= 1'b1;
          end else begin
            state     <= S_ISSUE;
            start_reg <= 1'b1;
          end
        end
        S_ISSUE, S_EXEC: begin
          if (responded) begin
            if (bus.run) begin
              state      <= S_FETCH;
              mem_rd_reg <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            state <= S_EXEC;
          end
        end
        S_HALT: begin
          state      <= S_HALT;
          halted_reg <= 1'b1;
        end
        default: begin
          state      <= S_IDLE;
          halted_reg <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_addr = pc_val;
  assign bus.pc       = pc_val;
  assign bus.mem_rd   = mem_rd_reg;
  assign bus.code     = code_reg;
  assign bus.start    = start_reg;
  assign bus.halted   = halted_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit. Two instances are built,
// MEM_LAT=1 and MEM_LAT=3, sharing one program memory and one controller
// stimulus; the instance not under test is held in reset.
module tb_fetch_unit;

  logic clk;
  logic rst1, rst3;
  logic run, inc_pc, branch;
  int   sel;
  int   ncmp, nfail;

  logic [22:0] mem [256];

  fetch_unit_if #(.PC_W(8), .INSTR_W(23)) b1 ();
  fetch_unit_if #(.PC_W(8), .INSTR_W(23)) b3 ();

  assign b1.run = run;  assign b1.inc_pc = inc_pc;  assign b1.branch = branch;
  assign b3.run = run;  assign b3.inc_pc = inc_pc;  assign b3.branch = branch;

  fetch_unit #(.PC_W(8), .INSTR_W(23), .MEM_LAT(1), .RESET_PC(0), .HALT_OP(3'b111))
    dut1 (.clk(clk), .rst(rst1), .bus(b1));
  fetch_unit #(.PC_W(8), .INSTR_W(23), .MEM_LAT(3), .RESET_PC(0), .HALT_OP(3'b111))
    dut3 (.clk(clk), .rst(rst3), .bus(b3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: data valid only in the cycle exactly LAT after mem_rd,
  // random garbage in every other cycle.
  initial begin : mem1_model
    int due_q[$];
    logic [7:0] adr_q[$];
    int c;
    c = 0;
    b1.mem_rdata = '0;
    forever begin
      @(negedge clk);
      c++;
      if (b1.mem_rd) begin due_q.push_back(c + 1); adr_q.push_back(b1.mem_addr); end
      if (due_q.size() > 0 && due_q[0] == c) begin
        b1.mem_rdata = mem[adr_q[0]];
        void'(due_q.pop_front()); void'(adr_q.pop_front());
      end else begin
        b1.mem_rdata = 23'($urandom);
      end
    end
  end

  initial begin : mem3_model
    int due_q[$];
    logic [7:0] adr_q[$];
    int c;
    c = 0;
    b3.mem_rdata = '0;
    forever begin
      @(negedge clk);
      c++;
      if (b3.mem_rd) begin due_q.push_back(c + 3); adr_q.push_back(b3.mem_addr); end
      if (due_q.size() > 0 && due_q[0] == c) begin
        b3.mem_rdata = mem[adr_q[0]];
        void'(due_q.pop_front()); void'(adr_q.pop_front());
      end else begin
        b3.mem_rdata = 23'($urandom);
      end
    end
  end

  logic        m_rd, m_start, m_halted;
  logic [7:0]  m_pc, m_addr;
  logic [22:0] m_code;
  always_comb begin
    if (sel == 0) begin
      m_rd = b1.mem_rd; m_start = b1.start; m_halted = b1.halted;
      m_pc = b1.pc; m_addr = b1.mem_addr; m_code = b1.code;
    end else begin
      m_rd = b3.mem_rd; m_start = b3.start; m_halted = b3.halted;
      m_pc = b3.pc; m_addr = b3.mem_addr; m_code = b3.code;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One instruction seen from the controller: entered in the FETCH cycle,
  // left in the cycle after the response edge.
  task automatic run_instr(input logic [7:0] eaddr, input logic [22:0] ecode,
                           input logic br, input logic inc, input int delay,
                           input int lat, input logic drop_run);
    int k;
    chk("fetch_rd", 32'(m_rd), 32'd1);
    chk("fetch_addr", 32'(m_addr), 32'(eaddr));
    chk("fetch_pc", 32'(m_pc), 32'(eaddr));
    k = 0;
    do begin
      inc_pc = 1'($urandom); branch = 1'($urandom);  // ignored outside ISSUE/EXEC
      step();
      k++;
    end while (!m_start && k < 20);
    inc_pc = 1'b0; branch = 1'b0;
    chk("start_latency", 32'(k), 32'(lat + 1));
    chk("issue_code", 32'(m_code), 32'(ecode));
    for (int d = 0; d < delay; d++) begin
      step();
      chk("exec_quiet", {30'd0, m_rd, m_start}, 32'd0);
      chk("exec_code", 32'(m_code), 32'(ecode));
    end
    branch = br; inc_pc = inc;
    if (drop_run) run = 1'b0;
    step();
    branch = 1'b0; inc_pc = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [22:0] instr;
    logic        br;
    logic        inc;
    int          delay;
  } vec_t;

  vec_t vecs[6];

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = {3'($urandom_range(0, 6)), 20'($urandom)};
  endtask

  // Transaction-level reference: next PC from the rules, instruction from memory.
  task automatic random_run(input int n, input int lat, inout logic [7:0] pc_model);
    logic br, inc;
    int dly;
    for (int i = 0; i < n; i++) begin
      br  = 1'($urandom_range(0, 1));
      inc = br ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = $urandom_range(0, 3);
      run_instr(pc_model, mem[pc_model], br, inc, dly, lat, 1'b0);
      if (br) pc_model = mem[pc_model][7:0];
      else    pc_model = pc_model + 8'd1;
    end
  endtask

  initial begin
    logic [7:0] pcm;
    int starts, rds;
    ncmp = 0; nfail = 0; sel = 0;
    rst1 = 1'b1; rst3 = 1'b1; run = 1'b0; inc_pc = 1'b0; branch = 1'b0;

    vecs[0] = '{addr: 8'h00, instr: 23'h012345, br: 1'b0, inc: 1'b1, delay: 0};
    vecs[1] = '{addr: 8'h01, instr: 23'h000040, br: 1'b1, inc: 1'b1, delay: 0};
    vecs[2] = '{addr: 8'h40, instr: 23'h1000FF, br: 1'b1, inc: 1'b0, delay: 2};
    vecs[3] = '{addr: 8'hFF, instr: 23'h200033, br: 1'b0, inc: 1'b1, delay: 1};
    vecs[4] = '{addr: 8'h00, instr: 23'h012345, br: 1'b1, inc: 1'b0, delay: 0};
    vecs[5] = '{addr: 8'h45, instr: 23'h3FFF05, br: 1'b1, inc: 1'b1, delay: 3};

    fill_random();
    for (int i = 0; i < 6; i++) mem[vecs[i].addr] = vecs[i].instr;
    mem[8'h05] = 23'h700000;

    step(); step();
    chk("rst_mem_rd", 32'(m_rd), 32'd0);
    chk("rst_start", 32'(m_start), 32'd0);
    chk("rst_halted", 32'(m_halted), 32'd0);
    chk("rst_pc", 32'(m_pc), 32'd0);
    chk("rst_code", 32'(m_code), 32'd0);

    // Cycle 0: IDLE sees run; FETCH follows in cycle 1.
    rst1 = 1'b0; run = 1'b1;
    chk("idle_no_rd", 32'(m_rd), 32'd0);
    step();
    for (int i = 0; i < 6; i++)
      run_instr(vecs[i].addr, vecs[i].instr, vecs[i].br, vecs[i].inc, vecs[i].delay, 1, 1'b0);

    // Halt instruction at 0x05.
    chk("halt_fetch_rd", 32'(m_rd), 32'd1);
    chk("halt_fetch_addr", 32'(m_addr), 32'h05);
    starts = 0; rds = 0;
    for (int i = 0; i < 50; i++) begin
      inc_pc = 1'($urandom); branch = 1'($urandom);
      step();
      starts += int'(m_start);
      rds += int'(m_rd);
    end
    inc_pc = 1'b0; branch = 1'b0;
    chk("halt_starts", 32'(starts), 32'd0);
    chk("halt_rds", 32'(rds), 32'd0);
    chk("halt_flag", 32'(m_halted), 32'd1);
    chk("halt_pc", 32'(m_pc), 32'h05);
    chk("halt_code", 32'(m_code), 32'h700000);
    rst1 = 1'b1;
    step();
    chk("unhalt_pc", 32'(m_pc), 32'd0);
    chk("unhalt_flag", 32'(m_halted), 32'd0);
    chk("unhalt_code", 32'(m_code), 32'd0);

    // Random program, MEM_LAT=1.
    fill_random();
    rst1 = 1'b0;
    step();
    pcm = 8'h00;
    random_run(40, 1, pcm);

    // run dropped while the instruction is outstanding.
    run_instr(pcm, mem[pcm], 1'b0, 1'b1, 2, 1, 1'b1);
    pcm = pcm + 8'd1;
    chk("park_pc", 32'(m_pc), 32'(pcm));
    rds = 0; starts = 0;
    for (int i = 0; i < 8; i++) begin
      rds += int'(m_rd); starts += int'(m_start);
      step();
    end
    chk("park_no_rd", 32'(rds), 32'd0);
    chk("park_no_start", 32'(starts), 32'd0);
    run = 1'b1;
    step();
    random_run(3, 1, pcm);

    // MEM_LAT=3 instance.
    rst1 = 1'b1; sel = 1; rst3 = 1'b0;
    step();
    pcm = 8'h00;
    random_run(20, 3, pcm);
    // Reset while in WAIT: the outstanding read must not be captured.
    step();
    chk("wait_state_rd", 32'(m_rd), 32'd0);
    rst3 = 1'b1;
    step();
    chk("wrst_mem_rd", 32'(m_rd), 32'd0);
    chk("wrst_start", 32'(m_start), 32'd0);
    chk("wrst_halted", 32'(m_halted), 32'd0);
    chk("wrst_pc", 32'(m_pc), 32'd0);
    chk("wrst_code", 32'(m_code), 32'd0);
    rst3 = 1'b0;
    step();
    pcm = 8'h00;
    random_run(5, 3, pcm);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
